// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop input synchroniser, start-bit glitch
// rejection, optional parity, 1 or 2 stop bits, sticky error flags and a
// clr_rdy handshake toward the consumer.
//
// state | meaning
// IDLE  | line idle, watching for a falling edge on rx_s
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sampling DATA_BITS data bits, LSB first
// PAR   | sampling the parity bit
// STOP  | sampling STOP_BITS stop bits, commit after the last one
// BREAK | a stop bit was low; wait for the line to return high
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 2604,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 clr_rdy,
    output logic                 rx_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    // The counter is loaded with N-1 so that ticks are exactly N cycles apart.
    localparam int              CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   rx_m;
    logic                   rx_s;
    logic                   rx_p;
    logic [CW-1:0]          cnt;
    logic                   tick;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   stop_bad;
    logic                   commit;
    logic                   ferr_now;
    logic                   perr_now;

    assign tick     = (cnt == '0);
    assign fall     = rx_p & ~rx_s;
    assign ferr_now = stop_bad | ~rx_s;
    assign perr_now = (PARITY != 0) & par_bad;

    // Synchroniser plus a delayed copy for start-edge detection; idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and the commit strobe on the final stop-bit tick.
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            IDLE:  if (fall) state_nx = START;
            START: if (tick) state_nx = rx_s ? IDLE : DATA;
            DATA:  if (tick && bit_cnt == LAST_DATA) state_nx = (PARITY != 0) ? PAR : STOP;
            PAR:   if (tick) state_nx = STOP;
            STOP: begin
                if (tick && bit_cnt == LAST_STOP) begin
                    commit   = 1'b1;
                    state_nx = ferr_now ? BREAK : IDLE;
                end
            end
            BREAK: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Baud down-counter, bit index, shift register and per-frame error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            cnt      <= fall ? HALF_LOAD : '0;
        end else if (state == BREAK) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= FULL_LOAD;
            if (state == START) bit_cnt <= '0;
            if (state == DATA) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
            end
            if (state == PAR)  par_bad <= ((^shreg) ^ rx_s) != (PARITY == 2);
            if (state == STOP) begin
                stop_bad <= stop_bad | ~rx_s;
                bit_cnt  <= bit_cnt + 4'd1;
            end
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Consumer-facing outputs; a commit takes priority over clr_rdy and then
    // reports only the new frame's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy     <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            rx_rdy     <= 1'b1;
            rx_data    <= shreg;
            overrun    <= clr_rdy ? 1'b0     : (overrun | rx_rdy);
            frame_err  <= clr_rdy ? ferr_now : (frame_err | ferr_now);
            parity_err <= clr_rdy ? perr_now : (parity_err | perr_now);
        end else if (clr_rdy) begin
            rx_rdy     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 uart_rx. Adds configurable data width, baud divisor, parity and stop-bit count. Adds an input synchroniser, start-bit glitch rejection, a clr_rdy handshake and sticky error flags (framing, parity, overrun). Sits between the board-level serial input pin and the command/packet layer.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
BAUD_DIV, 2604, clk cycles per bit; 2604 gives 19200 baud at 50 MHz; minimum 16.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
rx  input  1  serial line, idle high, asynchronous to clk.
clr_rdy  input  1  consumer acknowledge; clears rx_rdy and all error flags.
rx_rdy  output  1  a received frame is held in rx_data.
rx_data  output  DATA_BITS  last received data word.
frame_err  output  1  sticky: a stop bit was sampled low.
parity_err  output  1  sticky: parity mismatch; held at 0 when PARITY = 0.
overrun  output  1  sticky: a frame completed while rx_rdy was already high.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; counters 0; both synchroniser flops 1.
  - rx_rdy, frame_err, parity_err, overrun = 0; rx_data = 0.
  - Reset mid-frame abandons the frame; no partial data is committed.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s. Pin-to-decision latency is 2 cycles.
- Baud counter: loads and counts down; "tick" = the cycle the counter reaches 0.
- State machine:
  - IDLE: on rx_s falling edge (prev 1, now 0), load BAUD_DIV/2 (integer divide) and go to START.
  - START: on tick, if rx_s = 0, load BAUD_DIV, clear the bit index, go to DATA. If rx_s = 1, the start bit was a glitch; return to IDLE, no flags change.
  - DATA: on each tick, shift rx_s into the MSB of the shift register (LSB-first reception) and reload BAUD_DIV. After DATA_BITS samples, go to PAR if PARITY != 0, else to STOP.
  - PAR: on tick, capture the parity bit and reload BAUD_DIV. Even mode: XOR of data and parity must be 0. Odd mode: it must be 1. Go to STOP.
  - STOP: sample on each tick, STOP_BITS samples in total.
    - After the final stop sample, commit the frame (see below).
    - If any stop sample was 0, go to BREAK; otherwise go to IDLE.
  - BREAK: wait until rx_s = 1, then go to IDLE. A held-low line produces exactly one framing error, not repeated frames.
- Commit (the cycle after the final stop-bit tick):
  - rx_data <= shift register.
  - rx_rdy <= 1.
  - If rx_rdy was already 1 (and clr_rdy is not asserted this cycle), overrun <= 1.
  - frame_err and parity_err are set if their condition occurred; they are never cleared by a later good frame.
  - Data is committed even on error; the consumer checks the flags.
- clr_rdy:
  - Single-cycle or level; clears rx_rdy and all three error flags on the next edge.
  - If clr_rdy and commit occur in the same cycle, commit wins: rx_rdy = 1, flags reflect the new frame only, overrun = 0.
- Sampling point: mid-bit, at 1.5*BAUD_DIV ± 1 cycle after the synchronised start edge for data bit 0, then every BAUD_DIV cycles.
- Data errors: reception tolerates ±2% baud mismatch without data error.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP. No dead time beyond 1 cycle.
- Outputs are registered; no combinational path from rx to any output.

Test Plan:
- 8N1, BAUD_DIV = 2604, 10 ns clk: send 0xA5 with a 26040 ns bit period, 200 ns after reset. Required: rx_rdy rises within 1 bit of the stop-bit mid-point; rx_data = 0xA5; all flags 0.
- Three back-to-back 0xA5 frames with 1 idle bit between them and no clr_rdy:
  - after frame 2, overrun = 1;
  - after frame 3, rx_data = 0xA5 and overrun is still 1;
  - pulse clr_rdy → rx_rdy = 0 and overrun = 0.
- Glitch: drive rx low for 500 ns, then high. Required: rx_rdy stays 0 and the FSM returns to IDLE. Then send 0x3C → rx_data = 0x3C.
- PARITY = 1 (even), DATA_BITS = 7: send 0x55 with parity bit 1 (wrong). Required: rx_data = 0x55, rx_rdy = 1, parity_err = 1. Repeat with parity bit 0 after clr_rdy → parity_err = 0.
- STOP_BITS = 2: send 0x81 with the second stop bit low, then hold rx low for 5 bit periods, then release. Required:
  - exactly one commit, with frame_err = 1;
  - no further rx_rdy edges while the line is held low;
  - a following 0x81 frame with correct stops receives cleanly after clr_rdy.
- Reset mid-frame: assert rst_n low during data bit 4. Required: all outputs 0 immediately. The next full frame 0xF0 receives correctly.
